// File: rtl/imm_ext_unit.sv
// imm_ext_unit: buffered immediate extender.
// Extends an IN_W-bit immediate to OUT_W bits according to a 3-bit mode and
// queues {value, err} in a DEPTH-entry FIFO behind a valid/ready handshake.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        producer handshake (in_ready = FIFO not full)
//   in_imm, in_op            raw immediate and extension mode
//   out_valid/out_ready      consumer handshake on the FIFO head
//   out_imm, out_err         head value and illegal-mode flag (0 when empty)
//   err_cnt                  saturating count of accepted illegal modes
//   level                    current FIFO occupancy
module imm_ext_unit #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_imm,
  input  logic [2:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_imm,
  output logic                       out_err,
  output logic [7:0]                 err_cnt,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned HW = IN_W / 2;

  localparam logic [PW-1:0] PtrOne  = PW'(1);
  localparam logic [LW-1:0] LvlOne  = LW'(1);
  localparam logic [LW-1:0] LvlFull = LW'(DEPTH);

  logic [OUT_W:0]   mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             push, pop;
  logic             op_illegal;
  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] ext_val;

  // Handshake depends on registered state only; no out_ready -> in_ready path.
  assign in_ready  = (level_q != LvlFull);
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready & ~rst;
  assign pop       = out_valid & out_ready & ~rst;

  assign op_illegal = in_op[2] & (in_op[1:0] != 2'b00);
  assign sign_ext   = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    ext_val = '0;
    case (in_op)
      3'b000:  ext_val = sign_ext;
      3'b001:  ext_val = {{(OUT_W-IN_W){1'b0}}, in_imm};
      3'b010:  ext_val = {in_imm, {(OUT_W-IN_W){1'b0}}};
      // Upper two bits of the sign-extended value fall off the top.
      3'b011:  ext_val = {sign_ext[OUT_W-3:0], 2'b00};
      3'b100:  ext_val = {{(OUT_W-HW){1'b0}}, in_imm[HW-1:0]};
      default: ext_val = '0;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    err_cnt_d = err_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    if (push && !pop) level_d = level_q + LvlOne;
    if (pop && !push) level_d = level_q - LvlOne;
    if (push && op_illegal && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage needs no reset: contents are masked whenever level is zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {op_illegal, ext_val};
  end

  assign out_imm = out_valid ? mem_q[rd_ptr_q][OUT_W-1:0] : '0;
  assign out_err = out_valid ? mem_q[rd_ptr_q][OUT_W] : 1'b0;
  assign err_cnt = err_cnt_q;
  assign level   = level_q;

endmodule

// File: tb/tb_imm_ext_unit.sv
module tb_imm_ext_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic        out_err;
  logic [7:0]  err_cnt;
  logic [1:0]  level;

  int passed = 0;
  int total  = 0;

  // Reference model: queue of {err, value}, plus illegal-op counter.
  logic [32:0] q[$];
  int          m_err;
  bit          last_push;

  always #5 clk = ~clk;

  imm_ext_unit #(.IN_W(16), .OUT_W(32), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_imm  (out_imm),
    .out_err  (out_err),
    .err_cnt  (err_cnt),
    .level    (level)
  );

  // Extension computed arithmetically from the mode table.
  function automatic logic [32:0] ref_ext(input logic [15:0] imm, input logic [2:0] op);
    longint s;
    longint v;
    s = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
    case (op)
      3'd0: v = s;
      3'd1: v = longint'(imm);
      3'd2: v = longint'(imm) * 65536;
      3'd3: v = s * 4;
      3'd4: v = longint'(imm) % 256;
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, v[31:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock edge, with the model advanced from the pre-edge inputs.
  task automatic cycle();
    bit push;
    bit pop;
    logic [32:0] e;
    push = !rst && in_valid && (q.size() != DEPTH);
    pop  = !rst && out_ready && (q.size() != 0);
    e    = ref_ext(in_imm, in_op);
    @(posedge clk);
    #1;
    last_push = push;
    if (rst) begin
      q.delete();
      m_err = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(e);
        if (e[32] && m_err < 255) m_err++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit          ne;
    logic [32:0] head;
    ne   = (q.size() != 0);
    head = ne ? q[0] : 33'h0;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ne));
    check({tag, ".level"},     32'(level),     32'(q.size()));
    check({tag, ".in_ready"},  32'(in_ready),  32'(q.size() != DEPTH));
    check({tag, ".out_imm"},   out_imm,        head[31:0]);
    check({tag, ".out_err"},   32'(out_err),   32'(head[32]));
    check({tag, ".err_cnt"},   32'(err_cnt),   32'(m_err));
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [2:0] op,
                       input logic ordy);
    in_valid  = v;
    in_imm    = imm;
    in_op     = op;
    out_ready = ordy;
  endtask

  initial begin
    m_err = 0;
    rst = 1'b1;
    drive(1'b0, 16'h0, 3'd0, 1'b0);
    cycle();
    rst = 1'b0;
    check_all("reset");
    cycle();
    check_all("idle");

    // 1: sign extension of a negative immediate.
    drive(1'b1, 16'h8000, 3'd0, 1'b0);
    cycle();
    check_all("t1");
    check("t1.const", out_imm, 32'hFFFF8000);
    drive(1'b0, 16'h0, 3'd0, 1'b1);
    cycle();
    check_all("t1.pop");

    // 2: upper, branch, low modes with one in flight at a time.
    drive(1'b1, 16'h1234, 3'd2, 1'b0);
    cycle();
    check("t2.upper", out_imm, 32'h12340000);
    drive(1'b0, 16'h0, 3'd0, 1'b1); cycle();
    drive(1'b1, 16'hFFFF, 3'd3, 1'b0);
    cycle();
    check("t2.branch", out_imm, 32'hFFFFFFFC);
    drive(1'b0, 16'h0, 3'd0, 1'b1); cycle();
    drive(1'b1, 16'hABCD, 3'd4, 1'b0);
    cycle();
    check("t2.low", out_imm, 32'h000000CD);
    drive(1'b0, 16'h0, 3'd0, 1'b1); cycle();
    check_all("t2.drain");

    // 3: fill while stalled, third held, then one pop frees a slot.
    drive(1'b1, 16'h0011, 3'd1, 1'b0); cycle(); check_all("t3.a");
    drive(1'b1, 16'h0022, 3'd1, 1'b0); cycle(); check_all("t3.b");
    drive(1'b1, 16'h0033, 3'd1, 1'b0); cycle(); check_all("t3.held");
    check("t3.level", 32'(level), 32'd2);
    out_ready = 1'b1; cycle(); check_all("t3.pop");
    check("t3.ready_after_pop", 32'(in_ready), 32'd1);
    out_ready = 1'b0; cycle(); check_all("t3.accept3");
    check("t3.order", out_imm, 32'h00000022);
    drive(1'b0, 16'h0, 3'd0, 1'b1); cycle(); cycle(); check_all("t3.drain");

    // 4: streaming, one op per cycle with level held at 1.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(i * 3 + 1), 3'(i), 1'b1);
      cycle();
      check_all("t4");
    end
    drive(1'b0, 16'h0, 3'd0, 1'b1); cycle(); check_all("t4.drain");

    // 5: illegal ops and err_cnt saturation.
    drive(1'b1, 16'h5555, 3'd6, 1'b0); cycle(); check_all("t5.one");
    check("t5.err", 32'(out_err), 32'd1);
    drive(1'b0, 16'h0, 3'd0, 1'b1); cycle();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 16'(i), 3'(5 + (i % 3)), 1'b1);
      cycle();
      check_all("t5.sat");
    end
    check("t5.ff", 32'(err_cnt), 32'hFF);
    drive(1'b0, 16'h0, 3'd0, 1'b1); cycle(); check_all("t5.drain");

    // 6: reset while full.
    drive(1'b1, 16'h7777, 3'd0, 1'b0); cycle();
    drive(1'b1, 16'h8888, 3'd1, 1'b0); cycle(); check_all("t6.full");
    rst = 1'b1; cycle(); rst = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 1'b0);
    check_all("t6.rst");
    check("t6.level0", 32'(level), 32'd0);

    // Random traffic; producer holds its request while stalled.
    drive(1'b0, 16'h0, 3'd0, 1'b0);
    last_push = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (!in_valid || last_push) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        in_imm   = 16'($urandom());
        in_op    = 3'($urandom_range(0, 7));
      end
      out_ready = 1'($urandom_range(0, 2) != 0);
      cycle();
      check_all("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
